// File: rtl/framebuffer_write_scheduler.sv
// Buffers pixels from the Mandelbrot core and drives the framebuffer's
// four-phase write handshake (write_data / write_ack), one frame at a time.
module framebuffer_write_scheduler #(
  parameter int FRAME_PIXELS   = 76800,
  parameter int FIFO_DEPTH     = 4,
  parameter int PTR_RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [3:0] pix_data,
  output logic       pix_ready,
  output logic [3:0] write_data_in,
  output logic       write_data,
  output logic       reset_write_ptr,
  input  logic       write_ack,
  input  logic       read_busy,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       start_err
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PRC_W = (PTR_RST_CYCLES > 1) ? $clog2(PTR_RST_CYCLES) : 1;

  localparam logic [CNT_W-1:0] FRAME_LAST_C   = CNT_W'(FRAME_PIXELS);
  localparam logic [OCC_W-1:0] FIFO_FULL_C    = OCC_W'(FIFO_DEPTH);
  localparam logic [PRC_W-1:0] PTR_RST_LAST_C = PRC_W'(PTR_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PTR_RST = 3'd1,
    ST_WAIT    = 3'd2,
    ST_REQ     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t           state_r;
  logic [PRC_W-1:0] ptr_cnt_r;
  logic [CNT_W-1:0] acc_cnt_r;
  logic [CNT_W-1:0] wr_cnt_r;
  logic [CNT_W-1:0] wr_cnt_inc_s;

  logic [3:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;

  logic push_s;
  logic pop_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic pix_ready_s;
  logic frame_clear_s;

  logic [3:0] write_data_in_r;
  logic       write_data_r;
  logic       reset_write_ptr_r;
  logic       frame_busy_r;
  logic       frame_done_r;
  logic       start_err_r;

  // Handshake qualifiers; all derived from registered state so pix_ready has no input path.
  always_comb begin
    fifo_full_s   = (occ_r == FIFO_FULL_C);
    fifo_empty_s  = (occ_r == {OCC_W{1'b0}});
    pix_ready_s   = frame_busy_r && (state_r != ST_DONE) && !fifo_full_s &&
                    (acc_cnt_r < FRAME_LAST_C);
    push_s        = pix_valid && pix_ready_s;
    pop_s         = (state_r == ST_WAIT) && !fifo_empty_s && !read_busy;
    frame_clear_s = (state_r == ST_IDLE) && frame_start;
    wr_cnt_inc_s  = wr_cnt_r + CNT_W'(1);
  end

  // Pixel storage; only the write slot changes on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 4'h0;
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= pix_data;
    end
  end

  // FIFO pointers, occupancy and accepted-pixel count; a new frame starts them empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
    end else if (frame_clear_s) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r  <= wr_ptr_r + PTR_W'(1);
        acc_cnt_r <= acc_cnt_r + CNT_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Frame sequencing and framebuffer write handshake with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      ptr_cnt_r         <= {PRC_W{1'b0}};
      wr_cnt_r          <= {CNT_W{1'b0}};
      write_data_in_r   <= 4'h0;
      write_data_r      <= 1'b0;
      reset_write_ptr_r <= 1'b0;
      frame_busy_r      <= 1'b0;
      frame_done_r      <= 1'b0;
      start_err_r       <= 1'b0;
    end else begin
      if (frame_start && frame_busy_r) begin
        start_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            state_r           <= ST_PTR_RST;
            ptr_cnt_r         <= {PRC_W{1'b0}};
            wr_cnt_r          <= {CNT_W{1'b0}};
            reset_write_ptr_r <= 1'b1;
            frame_busy_r      <= 1'b1;
          end
        end
        ST_PTR_RST: begin
          if (ptr_cnt_r == PTR_RST_LAST_C) begin
            state_r           <= ST_WAIT;
            reset_write_ptr_r <= 1'b0;
          end else begin
            ptr_cnt_r <= ptr_cnt_r + PRC_W'(1);
          end
        end
        ST_WAIT: begin
          if (pop_s) begin
            state_r         <= ST_REQ;
            write_data_r    <= 1'b1;
            write_data_in_r <= fifo_mem_r[rd_ptr_r];
          end
        end
        ST_REQ: begin
          if (write_ack) begin
            state_r      <= ST_RELEASE;
            write_data_r <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // The write only counts once the framebuffer has released its acknowledge.
          if (!write_ack) begin
            wr_cnt_r <= wr_cnt_inc_s;
            if (wr_cnt_inc_s == FRAME_LAST_C) begin
              state_r      <= ST_DONE;
              frame_done_r <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          frame_done_r <= 1'b0;
          frame_busy_r <= 1'b0;
        end
        default: begin
          state_r           <= ST_IDLE;
          write_data_r      <= 1'b0;
          reset_write_ptr_r <= 1'b0;
          frame_busy_r      <= 1'b0;
          frame_done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready       = pix_ready_s;
  assign write_data_in   = write_data_in_r;
  assign write_data      = write_data_r;
  assign reset_write_ptr = reset_write_ptr_r;
  assign frame_busy      = frame_busy_r;
  assign frame_done      = frame_done_r;
  assign start_err       = start_err_r;

endmodule

// File: tb/tb_framebuffer_write_scheduler.sv
// Bench for framebuffer_write_scheduler: a directed vector table, hand-written
// corner sequences, and randomized frames checked against a pixel scoreboard.
module tb_framebuffer_write_scheduler;

  localparam int FP    = 8;
  localparam int DEPTH = 4;
  localparam int PRC   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       pix_valid;
  logic [3:0] pix_data;
  logic       pix_ready;
  logic [3:0] write_data_in;
  logic       write_data;
  logic       reset_write_ptr;
  logic       write_ack;
  logic       read_busy;
  logic       frame_busy;
  logic       frame_done;
  logic       start_err;

  framebuffer_write_scheduler #(
    .FRAME_PIXELS  (FP),
    .FIFO_DEPTH    (DEPTH),
    .PTR_RST_CYCLES(PRC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .write_data_in  (write_data_in),
    .write_data     (write_data),
    .reset_write_ptr(reset_write_ptr),
    .write_ack      (write_ack),
    .read_busy      (read_busy),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done),
    .start_err      (start_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fs;
    logic       pv;
    logic [3:0] pd;
    logic       ack;
    logic       rb;
    logic [9:0] exp;  // {pix_ready, write_data, reset_write_ptr, frame_busy, frame_done, start_err, write_data_in}
  } vec_t;

  vec_t tv [15];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_acc;
  int         n_wr;
  int         n_done;
  int         n_rwp;
  int         ack_dly;
  bit         saw_full;
  bit         err_model;
  logic [7:0] ack_hist;
  logic [3:0] src_q [$];
  logic [3:0] exp_q [$];

  function automatic logic [9:0] outs();
    return {pix_ready, write_data, reset_write_ptr, frame_busy, frame_done, start_err, write_data_in};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with scoreboard bookkeeping; the framebuffer echoes write_data after ack_dly cycles.
  task automatic cyc();
    logic       acc_s;
    logic       rb_s;
    logic       wd_s;
    logic       ack_s;
    logic [3:0] pd_s;
    acc_s = pix_valid && pix_ready;
    rb_s  = read_busy;
    wd_s  = write_data;
    ack_s = write_ack;
    pd_s  = pix_data;
    @(posedge clk);
    #1;
    if (acc_s) begin
      exp_q.push_back(pd_s);
      n_acc++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (write_data && !wd_s) begin
      chk("write_while_read_busy", rb_s, 1'b0);
      chk("write_has_pixel", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("write_order", write_data_in, exp_q.pop_front());
      n_wr++;
    end
    if (wd_s && !ack_s) chk("req_held", write_data, 1'b1);
    if (exp_q.size() == DEPTH) begin
      saw_full = 1'b1;
      chk("full_stall", pix_ready, 1'b0);
    end
    if (n_acc == FP) chk("frame_cap", pix_ready, 1'b0);
    if (frame_done) n_done++;
    if (reset_write_ptr) begin
      n_rwp++;
      chk("ptr_rst_first", n_wr, 0);
    end
    ack_hist  = {ack_hist[6:0], write_data};
    write_ack = ack_hist[ack_dly-1];
  endtask

  task automatic drive_random(input int vprob, input int rbprob);
    pix_valid = (src_q.size() > 0) && (int'($urandom_range(99)) < vprob);
    pix_data  = (src_q.size() > 0) ? src_q[0] : 4'h0;
    read_busy = (int'($urandom_range(99)) < rbprob);
  endtask

  task automatic begin_frame(input bit ramp);
    n_acc    = 0;
    n_wr     = 0;
    n_done   = 0;
    n_rwp    = 0;
    saw_full = 1'b0;
    exp_q.delete();
    src_q.delete();
    for (int i = 0; i <= FP; i++) begin
      src_q.push_back(ramp ? 4'(i + 1) : 4'($urandom_range(15)));
    end
    pix_valid   = 1'b0;
    read_busy   = 1'b0;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic complete_frame(input int vprob, input int rbprob, input bit mid_start);
    int post;
    bit mid_done;
    post     = 0;
    mid_done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      drive_random(vprob, rbprob);
      if (mid_start && !mid_done && n_acc >= 3 && n_done == 0) begin
        frame_start = 1'b1;
        mid_done    = 1'b1;
        err_model   = 1'b1;
      end
      cyc();
      frame_start = 1'b0;
      if (n_done > 0) post++;
      if (post >= 4) break;
    end
    pix_valid = 1'b0;
    read_busy = 1'b0;
    chk("frame_timeout", post >= 4, 1'b1);
    chk("frame_writes", n_wr, FP);
    chk("frame_accepts", n_acc, FP);
    chk("frame_done_pulses", n_done, 1);
    chk("ptr_rst_cycles", n_rwp, PRC);
    chk("idle_after_done", frame_busy, 1'b0);
    chk("start_err_sticky", start_err, err_model);
    chk("fifo_drained", exp_q.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 4'h0;
    write_ack   = 1'b0;
    read_busy   = 1'b0;
    ack_hist    = 8'h00;
    ack_dly     = 1;
    err_model   = 1'b0;

    //           fs    pv    pd    ack   rb    pr wd rp fb fd se wdi
    tv[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 10'b0_0_0_0_0_0_0000};
    tv[1]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 10'b1_0_1_1_0_0_0000};
    tv[2]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 10'b1_0_1_1_0_0_0000};
    tv[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 10'b1_0_0_1_0_0_0000};
    tv[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 10'b1_0_0_1_0_0_0000};
    tv[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 10'b1_1_0_1_0_0_0101};
    tv[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 10'b1_1_0_1_0_1_0101};
    tv[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 10'b1_0_0_1_0_1_0101};
    tv[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 10'b1_0_0_1_0_1_0101};
    tv[9]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 10'b1_0_0_1_0_1_0101};
    tv[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 10'b1_1_0_1_0_1_1010};
    tv[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 10'b1_0_0_1_0_1_1010};
    tv[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 10'b1_0_0_1_0_1_1010};
    tv[13] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 10'b1_0_0_1_0_1_1010};
    tv[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 10'b1_1_0_1_0_1_0011};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 10'h000);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      frame_start = tv[i].fs;
      pix_valid   = tv[i].pv;
      pix_data    = tv[i].pd;
      write_ack   = tv[i].ack;
      read_busy   = tv[i].rb;
      @(posedge clk);
      #1;
      chk($sformatf("vector_%0d", i), outs(), tv[i].exp);
    end

    // Reset lands while write_data is high: outputs must drop before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_write", outs(), 10'h000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Frame 0: read_busy held for 10 cycles, then raised again during REQ, plus a stray frame_start.
    ack_dly = 3;
    begin_frame(1'b0);
    pix_valid = 1'b1;
    pix_data  = src_q[0];
    read_busy = 1'b1;
    cyc();
    pix_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rb_hold_no_write", write_data, 1'b0);
    end
    read_busy = 1'b0;
    cyc();
    chk("req_after_rb_fall", write_data, 1'b1);
    read_busy = 1'b1;
    cyc();
    chk("rb_no_abort", write_data, 1'b1);
    complete_frame(70, 20, 1'b1);

    // Frame 1: ramp 1..8 (9th offered and refused), acknowledge one cycle after the request.
    ack_dly = 1;
    begin_frame(1'b1);
    complete_frame(100, 0, 1'b0);

    // Frame 2: continuous source against a slow framebuffer fills the FIFO.
    ack_dly = 5;
    begin_frame(1'b0);
    complete_frame(100, 0, 1'b0);
    chk("fifo_filled", saw_full, 1'b1);

    for (int f = 0; f < 3; f++) begin
      ack_dly = 1 + int'($urandom_range(5));
      begin_frame(1'b0);
      complete_frame(30 + int'($urandom_range(70)), int'($urandom_range(40)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
